// File: rtl/down_counter_timer.sv
// -----------------------------------------------------------------------------
// down_counter_timer
//
// Loadable down-counter used as a programmable delay / timeout source.
// A load request sets the start value; the count steps down by one on every
// enabled cycle while running. Reaching zero produces a one-cycle tc pulse
// and a held done level that stays high until the consumer acknowledges it
// or issues a new load. With AUTO_RELOAD=1 the counter shows zero for one
// cycle, then restarts from the last loaded value and never enters DONE.
//
// State table:
//   state | meaning
//   IDLE  | no count in progress, waiting for load
//   RUN   | counting down on enabled cycles (busy=1)
//   DONE  | terminal count reached, done=1 until ack or load
//
// Ports:
//   clk_i        rising-edge clock
//   reset_i      synchronous active-low reset
//   enable_i     count-step qualifier, only honoured in RUN
//   load_i       start/restart request, samples load_value_i on the same edge
//   load_value_i start value (WIDTH bits)
//   ack_i        consumer acknowledge of done
//   count_o      current count (registered)
//   busy_o       high while in RUN (registered)
//   done_o       completion level (registered)
//   tc_o         one-cycle terminal-count pulse (registered)
// -----------------------------------------------------------------------------
module down_counter_timer #(
    parameter int unsigned WIDTH       = 4,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             ack_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             tc_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             tc_q,     tc_d;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tc_q     <= tc_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = done_q;
        tc_d     = 1'b0;

        // A load is handled identically in every state, so it is resolved
        // first and the per-state logic only runs when no load is present.
        if (load_i) begin
            count_d  = load_value_i;
            reload_d = load_value_i;
            if (load_value_i == CNT_ZERO) begin
                // Zero start value completes immediately.
                state_d = ST_DONE;
                done_d  = 1'b1;
                tc_d    = 1'b1;
            end else begin
                state_d = ST_RUN;
                done_d  = 1'b0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    count_d = count_q;
                end

                ST_RUN: begin
                    if (enable_i) begin
                        if (count_q > CNT_ONE) begin
                            count_d = count_q - CNT_ONE;
                        end else if (count_q == CNT_ONE) begin
                            count_d = CNT_ZERO;
                            tc_d    = 1'b1;
                            if (!AUTO_RELOAD) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end
                        end else if (AUTO_RELOAD) begin
                            // Zero is shown for one cycle in auto-reload mode;
                            // the next enabled step restarts from the stored
                            // value itself, not one below it.
                            count_d = reload_q;
                        end
                    end
                end

                ST_DONE: begin
                    count_d = CNT_ZERO;
                    if (ack_i) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b0;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    count_d = CNT_ZERO;
                    done_d  = 1'b0;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN);
    end

    assign count_o = count_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign tc_o    = tc_q;

endmodule

// File: tb/tb_down_counter_timer.sv
module tb_down_counter_timer;

    localparam int W = 4;

    logic         clk_i = 1'b0;
    // instance A: AUTO_RELOAD = 0
    logic         a_reset, a_enable, a_load, a_ack;
    logic [W-1:0] a_load_value;
    logic [W-1:0] a_count;
    logic         a_busy, a_done, a_tc;
    // instance B: AUTO_RELOAD = 1
    logic         b_reset, b_enable, b_load, b_ack;
    logic [W-1:0] b_load_value;
    logic [W-1:0] b_count;
    logic         b_busy, b_done, b_tc;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    down_counter_timer #(.WIDTH(W), .AUTO_RELOAD(1'b0)) u_dut_a (
        .clk_i        (clk_i),
        .reset_i      (a_reset),
        .enable_i     (a_enable),
        .load_i       (a_load),
        .load_value_i (a_load_value),
        .ack_i        (a_ack),
        .count_o      (a_count),
        .busy_o       (a_busy),
        .done_o       (a_done),
        .tc_o         (a_tc)
    );

    down_counter_timer #(.WIDTH(W), .AUTO_RELOAD(1'b1)) u_dut_b (
        .clk_i        (clk_i),
        .reset_i      (b_reset),
        .enable_i     (b_enable),
        .load_i       (b_load),
        .load_value_i (b_load_value),
        .ack_i        (b_ack),
        .count_o      (b_count),
        .busy_o       (b_busy),
        .done_o       (b_done),
        .tc_o         (b_tc)
    );

    typedef struct {
        string        name;
        logic         rst_n;
        logic         load;
        logic [W-1:0] lv;
        logic         en;
        logic         ack;
        logic [W-1:0] exp_count;
        logic         exp_busy;
        logic         exp_done;
        logic         exp_tc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic rst_n, logic load, int lv,
                                logic en, logic ack, int c, logic b, logic d,
                                logic t);
        vec_t v;
        v.name = name; v.rst_n = rst_n; v.load = load; v.lv = W'(lv);
        v.en = en; v.ack = ack; v.exp_count = W'(c);
        v.exp_busy = b; v.exp_done = d; v.exp_tc = t;
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_a(string nm, int c, logic b, logic d, logic t);
        chk({nm, ".count"}, int'(a_count), c);
        chk({nm, ".busy"},  int'(a_busy),  int'(b));
        chk({nm, ".done"},  int'(a_done),  int'(d));
        chk({nm, ".tc"},    int'(a_tc),    int'(t));
    endtask

    task automatic chk_b(string nm, int c, logic b, logic d, logic t);
        chk({nm, ".count"}, int'(b_count), c);
        chk({nm, ".busy"},  int'(b_busy),  int'(b));
        chk({nm, ".done"},  int'(b_done),  int'(d));
        chk({nm, ".tc"},    int'(b_tc),    int'(t));
    endtask

    // drive A, take one rising edge, sample 1 time unit later
    task automatic step_a(logic rst_n, logic load, int lv, logic en, logic ack);
        a_reset = rst_n; a_load = load; a_load_value = W'(lv);
        a_enable = en; a_ack = ack;
        @(posedge clk_i);
        #1;
    endtask

    task automatic step_b(logic rst_n, logic load, int lv, logic en, logic ack);
        b_reset = rst_n; b_load = load; b_load_value = W'(lv);
        b_enable = en; b_ack = ack;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        a_reset = 1'b0; a_load = 1'b0; a_load_value = '0; a_enable = 1'b0; a_ack = 1'b0;
        b_reset = 1'b0; b_load = 1'b0; b_load_value = '0; b_enable = 1'b0; b_ack = 1'b0;

        //                 name        rst ld  lv en ack  cnt busy done tc
        vecs.push_back(mk("rst0",      0,  0,  0, 0, 0,   0,  0,   0,   0));
        vecs.push_back(mk("rst1",      0,  1,  9, 1, 1,   0,  0,   0,   0));
        // basic countdown from 5
        vecs.push_back(mk("bas_ld5",   1,  1,  5, 0, 0,   5,  1,   0,   0));
        vecs.push_back(mk("bas_4",     1,  0,  0, 1, 0,   4,  1,   0,   0));
        vecs.push_back(mk("bas_3",     1,  0,  0, 1, 1,   3,  1,   0,   0));
        vecs.push_back(mk("bas_2",     1,  0,  0, 1, 0,   2,  1,   0,   0));
        vecs.push_back(mk("bas_1",     1,  0,  0, 1, 0,   1,  1,   0,   0));
        vecs.push_back(mk("bas_0",     1,  0,  0, 1, 0,   0,  0,   1,   1));
        vecs.push_back(mk("bas_hold",  1,  0,  0, 1, 0,   0,  0,   1,   0));
        vecs.push_back(mk("bas_ack",   1,  0,  0, 0, 1,   0,  0,   0,   0));
        vecs.push_back(mk("idle_ign",  1,  0,  0, 1, 1,   0,  0,   0,   0));
        // pause pattern 1,0,0,1,1
        vecs.push_back(mk("pau_ld3",   1,  1,  3, 0, 0,   3,  1,   0,   0));
        vecs.push_back(mk("pau_e1",    1,  0,  0, 1, 0,   2,  1,   0,   0));
        vecs.push_back(mk("pau_e0a",   1,  0,  0, 0, 0,   2,  1,   0,   0));
        vecs.push_back(mk("pau_e0b",   1,  0,  0, 0, 1,   2,  1,   0,   0));
        vecs.push_back(mk("pau_e1b",   1,  0,  0, 1, 0,   1,  1,   0,   0));
        vecs.push_back(mk("pau_e1c",   1,  0,  0, 1, 0,   0,  0,   1,   1));
        vecs.push_back(mk("pau_ack",   1,  0,  0, 0, 1,   0,  0,   0,   0));
        // zero load
        vecs.push_back(mk("z_ld0",     1,  1,  0, 0, 0,   0,  0,   1,   1));
        vecs.push_back(mk("z_hold",    1,  0,  0, 1, 0,   0,  0,   1,   0));
        vecs.push_back(mk("z_ack",     1,  0,  0, 0, 1,   0,  0,   0,   0));
        // load beats enable at count=1
        vecs.push_back(mk("pr_ld2",    1,  1,  2, 0, 0,   2,  1,   0,   0));
        vecs.push_back(mk("pr_1",      1,  0,  0, 1, 0,   1,  1,   0,   0));
        vecs.push_back(mk("pr_ld7",    1,  1,  7, 1, 0,   7,  1,   0,   0));
        vecs.push_back(mk("pr_6",      1,  0,  0, 1, 0,   6,  1,   0,   0));
        // restart with zero from RUN
        vecs.push_back(mk("pr_rl0",    1,  1,  0, 1, 0,   0,  0,   1,   1));
        // load beats ack in DONE
        vecs.push_back(mk("pr_ldack",  1,  1,  4, 0, 1,   4,  1,   0,   0));
        vecs.push_back(mk("pr_3",      1,  0,  0, 1, 0,   3,  1,   0,   0));
        vecs.push_back(mk("pr_2",      1,  0,  0, 1, 0,   2,  1,   0,   0));
        // reset mid-count at count=2
        vecs.push_back(mk("mr_run",    0,  0,  0, 1, 0,   0,  0,   0,   0));
        vecs.push_back(mk("mr_ack",    1,  0,  0, 1, 1,   0,  0,   0,   0));
        // reset while done
        vecs.push_back(mk("md_ld0",    1,  1,  0, 0, 0,   0,  0,   1,   1));
        vecs.push_back(mk("md_rst",    0,  0,  0, 0, 0,   0,  0,   0,   0));
        vecs.push_back(mk("md_ack",    1,  0,  0, 0, 1,   0,  0,   0,   0));
        vecs.push_back(mk("md_en",     1,  0,  0, 1, 0,   0,  0,   0,   0));

        for (int i = 0; i < vecs.size(); i++) begin
            step_a(vecs[i].rst_n, vecs[i].load, int'(vecs[i].lv), vecs[i].en, vecs[i].ack);
            chk_a(vecs[i].name, int'(vecs[i].exp_count), vecs[i].exp_busy,
                  vecs[i].exp_done, vecs[i].exp_tc);
        end

        // max load: 15 enabled edges to terminal count, no wrap afterwards
        step_a(1, 1, 15, 0, 0);
        chk_a("max_ld", 15, 1, 0, 0);
        for (int i = 1; i <= 15; i++) begin
            step_a(1, 0, 0, 1, 0);
            chk_a($sformatf("max_%0d", i), 15 - i, (i != 15), (i == 15), (i == 15));
        end
        for (int i = 0; i < 3; i++) begin
            step_a(1, 0, 0, 1, 0);
            chk_a($sformatf("max_nowrap%0d", i), 0, 0, 1, 0);
        end
        step_a(1, 0, 0, 0, 1);
        chk_a("max_ack", 0, 0, 0, 0);

        // auto-reload instance
        step_b(0, 0, 0, 0, 0);
        chk_b("ar_rst", 0, 0, 0, 0);
        step_b(1, 1, 3, 0, 0);
        chk_b("ar_ld3", 3, 1, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            step_b(1, 0, 0, 1, 0);
            chk_b($sformatf("ar_%0d", i), 3 - (i % 4), 1, 0, ((i % 4) == 3));
        end
        // hold at zero while disabled, then reload to full value
        step_b(1, 0, 0, 1, 0);
        chk_b("ar_r1", 2, 1, 0, 0);
        step_b(1, 0, 0, 1, 0);
        chk_b("ar_r2", 1, 1, 0, 0);
        step_b(1, 0, 0, 1, 0);
        chk_b("ar_r3", 0, 1, 0, 1);
        step_b(1, 0, 0, 0, 0);
        chk_b("ar_pause0", 0, 1, 0, 0);
        step_b(1, 0, 0, 1, 1);
        chk_b("ar_reload", 3, 1, 0, 0);
        // load with enable at count=1 in auto mode: load wins, no tc
        step_b(1, 0, 0, 1, 0);
        step_b(1, 0, 0, 1, 0);
        chk_b("ar_c1", 1, 1, 0, 0);
        step_b(1, 1, 6, 1, 0);
        chk_b("ar_ld6", 6, 1, 0, 0);
        step_b(0, 0, 0, 1, 0);
        chk_b("ar_midrst", 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
